// File: rtl/lcd_timing_pkg.sv
// Shared types and panel defaults for the LCD raster timing generator.
package lcd_timing_pkg;

   // Phase of one raster axis, in the order it is traversed.
   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      BPORCH = 2'd1,
      ACTIVE = 2'd2,
      FPORCH = 2'd3
   } phase_t;

   // Default timing for the 480x272 panel.
   localparam int DEF_H_ACTIVE = 480;
   localparam int DEF_H_FP     = 2;
   localparam int DEF_H_SYNC   = 41;
   localparam int DEF_H_BP     = 2;
   localparam int DEF_V_ACTIVE = 272;
   localparam int DEF_V_FP     = 2;
   localparam int DEF_V_SYNC   = 10;
   localparam int DEF_V_BP     = 2;
   localparam int DEF_CW       = 10;

   // Counter width able to hold total-1, never narrower than 10 bits.
   function automatic int cnt_width(input int total);
      int w;
      w = $clog2(total);
      if (w < 10) w = 10;
      return w;
   endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One raster axis: position counter plus the SYNC/BPORCH/ACTIVE/FPORCH phase FSM.
// The counter and phase advance only when en is high; wrap flags the last count.
module lcd_axis_counter
   import lcd_timing_pkg::*;
#(
   parameter int SYNC_LEN = DEF_H_SYNC,
   parameter int BP_LEN   = DEF_H_BP,
   parameter int ACT_LEN  = DEF_H_ACTIVE,
   parameter int FP_LEN   = DEF_H_FP,
   parameter int W        = cnt_width(SYNC_LEN + BP_LEN + ACT_LEN + FP_LEN)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic [1:0]   phase,
   output logic         wrap
);

   localparam int TOTAL = SYNC_LEN + BP_LEN + ACT_LEN + FP_LEN;
   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] SYNC_END = W'(SYNC_LEN - 1);
   localparam logic [W-1:0] BP_END   = W'(SYNC_LEN + BP_LEN - 1);
   localparam logic [W-1:0] ACT_END  = W'(SYNC_LEN + BP_LEN + ACT_LEN - 1);

   if (SYNC_LEN < 1 || BP_LEN < 1 || FP_LEN < 1 || ACT_LEN < 1) begin : g_len_chk
      $error("lcd_axis_counter: every sync/porch/active length must be >= 1");
   end

   phase_t state, state_nxt;

   assign wrap  = en && (cnt == LAST);
   assign phase = state;

   // Position counter: 0..TOTAL-1, wrapping back to 0.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (en)
         cnt <= wrap ? '0 : cnt + W'(1);
   end

   // Phase state register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= SYNC;
      else
         state <= state_nxt;
   end

   // Next phase: move on when the counter sits on the last count of the current phase.
   always_comb begin
      state_nxt = state;
      if (en) begin
         case (state)
            SYNC:    if (cnt == SYNC_END) state_nxt = BPORCH;
            BPORCH:  if (cnt == BP_END)   state_nxt = ACTIVE;
            ACTIVE:  if (cnt == ACT_END)  state_nxt = FPORCH;
            FPORCH:  if (cnt == LAST)     state_nxt = SYNC;
            default:                      state_nxt = SYNC;
         endcase
      end
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing for the parallel RGB LCD: HS, VS, DE, active x/y and
// line/frame start strobes, all registered one clock after the counter state.
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = DEF_CW
) (
   input  logic          rgb_clk,
   input  logic          rgb_rst,
   output logic          rgb_hs,
   output logic          rgb_vs,
   output logic          rgb_de,
   output logic [CW-1:0] rgb_x,
   output logic [CW-1:0] rgb_y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int HW = cnt_width(H_SYNC + H_BP + H_ACTIVE + H_FP);
   localparam int VW = cnt_width(V_SYNC + V_BP + V_ACTIVE + V_FP);

   if (H_ACTIVE > (1 << CW) || V_ACTIVE > (1 << CW)) begin : g_cw_chk
      $error("lcd_timing_gen: CW too narrow for H_ACTIVE/V_ACTIVE");
   end

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [1:0]    h_phase, v_phase;
   logic          h_wrap, v_wrap;

   lcd_axis_counter #(
      .SYNC_LEN (H_SYNC),
      .BP_LEN   (H_BP),
      .ACT_LEN  (H_ACTIVE),
      .FP_LEN   (H_FP),
      .W        (HW)
   ) u_h (
      .clk   (rgb_clk),
      .rst   (rgb_rst),
      .en    (1'b1),
      .cnt   (h_cnt),
      .phase (h_phase),
      .wrap  (h_wrap)
   );

   // The vertical axis steps once per line, on the horizontal wrap.
   lcd_axis_counter #(
      .SYNC_LEN (V_SYNC),
      .BP_LEN   (V_BP),
      .ACT_LEN  (V_ACTIVE),
      .FP_LEN   (V_FP),
      .W        (VW)
   ) u_v (
      .clk   (rgb_clk),
      .rst   (rgb_rst),
      .en    (h_wrap),
      .cnt   (v_cnt),
      .phase (v_phase),
      .wrap  (v_wrap)
   );

   logic [HW-1:0] h_off;
   logic [VW-1:0] v_off;
   logic          de_p0, line_p0, frame_top;
   logic [CW-1:0] x_p0, y_p0;

   assign h_off = h_cnt - HW'(H_SYNC + H_BP);
   assign v_off = v_cnt - VW'(V_SYNC + V_BP);

   // Decode of the current counter state, before the output register.
   always_comb begin
      de_p0 = (h_phase == ACTIVE) && (v_phase == ACTIVE);
      x_p0  = '0;
      y_p0  = '0;
      if (de_p0) begin
         x_p0 = CW'(h_off);
         y_p0 = CW'(v_off);
      end
      line_p0 = de_p0 && (x_p0 == '0);
   end

   // Top-of-frame flag: armed by reset and by the vertical wrap, cleared once
   // the first active line of the frame has started, so only y=0 raises frame_start.
   always_ff @(posedge rgb_clk) begin
      if (rgb_rst)
         frame_top <= 1'b1;
      else if (v_wrap)
         frame_top <= 1'b1;
      else if (line_p0)
         frame_top <= 1'b0;
   end

   // Output register: everything the panel and pixel source see is one clock behind the counters.
   always_ff @(posedge rgb_clk) begin
      if (rgb_rst) begin
         rgb_hs      <= ~HS_POL;
         rgb_vs      <= ~VS_POL;
         rgb_de      <= 1'b0;
         rgb_x       <= '0;
         rgb_y       <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         rgb_hs      <= (h_phase == SYNC) ? HS_POL : ~HS_POL;
         rgb_vs      <= (v_phase == SYNC) ? VS_POL : ~VS_POL;
         rgb_de      <= de_p0;
         rgb_x       <= x_p0;
         rgb_y       <= y_p0;
         line_start  <= line_p0;
         frame_start <= line_p0 && frame_top;
      end
   end

endmodule
